// File: rtl/mem_lsu_if.sv
// mem_lsu_if: EXE->MEM inputs, MEM->WB outputs and exception status of the load/store unit.
// The master modport is the pipeline/interrupt side; the slave modport is the LSU itself.
interface mem_lsu_if;
    logic        mem_wreg;
    logic        mem_m2reg;
    logic        mem_wmem;
    logic [4:0]  mem_rn;
    logic [31:0] mem_alu;
    logic [31:0] mem_b;
    logic        mem_uns;
    logic        mem_half;
    logic        mem_byte;
    logic        exc_ack;
    logic        wb_wreg;
    logic        wb_m2reg;
    logic [4:0]  wb_rn;
    logic [31:0] wb_alu;
    logic [31:0] wb_mdata;
    logic        mem_adel;
    logic        mem_ades;
    logic        exc_adel;
    logic        exc_ades;
    logic [31:0] badvaddr;

    modport master (
        output mem_wreg, mem_m2reg, mem_wmem, mem_rn, mem_alu, mem_b,
        output mem_uns, mem_half, mem_byte, exc_ack,
        input  wb_wreg, wb_m2reg, wb_rn, wb_alu, wb_mdata,
        input  mem_adel, mem_ades, exc_adel, exc_ades, badvaddr
    );

    modport slave (
        input  mem_wreg, mem_m2reg, mem_wmem, mem_rn, mem_alu, mem_b,
        input  mem_uns, mem_half, mem_byte, exc_ack,
        output wb_wreg, wb_m2reg, wb_rn, wb_alu, wb_mdata,
        output mem_adel, mem_ades, exc_adel, exc_ades, badvaddr
    );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with a byte-lane data RAM and MEM->WB registers.
// Macro LSU_ALIGN_CHK_EN enables misalignment faults, sticky flags and badvaddr capture.
module mem_lsu #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_BADV = 32'h0000_0000
) (
    input logic      clk,
    input logic      clrn,
    mem_lsu_if.slave lsu
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           ram [DEPTH];
    logic [31:0]           a;
    logic                  is_byte;
    logic                  is_half;
    logic                  is_word;
    logic                  misaligned;
    logic [1:0]            lo;
    logic [ADDR_WIDTH-1:0] idx;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [31:0]           rword;
    logic [7:0]            rbyte;
    logic [15:0]           rhalf;
    logic [31:0]           ldata;
    logic                  st_en;
    logic                  fault;
    logic                  unused_ok;

    assign a       = lsu.mem_alu;
    assign is_byte = lsu.mem_byte;
    assign is_half = ~lsu.mem_byte & lsu.mem_half;
    assign is_word = ~lsu.mem_byte & ~lsu.mem_half;
    assign idx     = a[ADDR_WIDTH+1:2];

`ifdef LSU_ALIGN_CHK_EN
    assign misaligned = (is_half & a[0]) | (is_word & (a[1:0] != 2'b00));
    assign lo         = a[1:0];
    assign unused_ok  = ^a[31:ADDR_WIDTH+2];
`else
    assign misaligned = 1'b0;
    assign lo         = is_byte ? a[1:0] : (is_half ? {a[1], 1'b0} : 2'b00);
    assign unused_ok  = ^{a[31:ADDR_WIDTH+2], lsu.exc_ack};
`endif

    assign lsu.mem_adel = lsu.mem_m2reg & misaligned;
    assign lsu.mem_ades = lsu.mem_wmem & misaligned;
    assign fault        = lsu.mem_adel | lsu.mem_ades;
    assign st_en        = clrn & lsu.mem_wmem & ~misaligned;

    // Lane enables and lane-replicated store data for the access size
    always_comb begin
        be    = 4'b1111;
        wdata = lsu.mem_b;
        unique case (1'b1)
            is_byte: begin
                be    = 4'b0001 << lo;
                wdata = {4{lsu.mem_b[7:0]}};
            end
            is_half: begin
                be    = lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{lsu.mem_b[15:0]}};
            end
            is_word: begin
                be    = 4'b1111;
                wdata = lsu.mem_b;
            end
        endcase
    end

    // Store: write only the enabled byte lanes of the addressed word
    always_ff @(posedge clk) begin
        if (st_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    ram[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rword = ram[idx];
    assign rbyte = rword[{lo, 3'b000} +: 8];
    assign rhalf = rword[{lo[1], 4'b0000} +: 16];

    // Load extraction with sign or zero extension
    always_comb begin
        ldata = rword;
        unique case (1'b1)
            is_byte: ldata = {{24{~lsu.mem_uns & rbyte[7]}}, rbyte};
            is_half: ldata = {{16{~lsu.mem_uns & rhalf[15]}}, rhalf};
            is_word: ldata = rword;
        endcase
    end

    // MEM->WB pipeline register; a faulting access loses its register write
    always_ff @(posedge clk) begin
        if (!clrn) begin
            lsu.wb_wreg  <= 1'b0;
            lsu.wb_m2reg <= 1'b0;
            lsu.wb_rn    <= 5'd0;
            lsu.wb_alu   <= 32'd0;
            lsu.wb_mdata <= 32'd0;
        end else begin
            lsu.wb_wreg  <= lsu.mem_wreg & ~fault;
            lsu.wb_m2reg <= lsu.mem_m2reg;
            lsu.wb_rn    <= lsu.mem_rn;
            lsu.wb_alu   <= lsu.mem_alu;
            lsu.wb_mdata <= ldata;
        end
    end

`ifdef LSU_ALIGN_CHK_EN
    // Sticky fault flags held until acknowledged; a new fault beats the ack
    always_ff @(posedge clk) begin
        if (!clrn) begin
            lsu.exc_adel <= 1'b0;
            lsu.exc_ades <= 1'b0;
            lsu.badvaddr <= RESET_BADV;
        end else begin
            lsu.exc_adel <= lsu.mem_adel | (lsu.exc_adel & ~lsu.exc_ack);
            lsu.exc_ades <= lsu.mem_ades | (lsu.exc_ades & ~lsu.exc_ack);
            if (fault) begin
                lsu.badvaddr <= a;
            end
        end
    end
`else
    assign lsu.exc_adel = 1'b0;
    assign lsu.exc_ades = 1'b0;
    assign lsu.badvaddr = RESET_BADV;
`endif
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized and directed checks of mem_lsu against a byte-array reference model.
// Expectations follow LSU_ALIGN_CHK_EN the same way the design does.
module tb_mem_lsu;
    localparam logic [31:0] RESET_BADV = 32'hBFC0_0180;
`ifdef LSU_ALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk;
    logic clrn;
    mem_lsu_if bus ();

    mem_lsu #(
        .ADDR_WIDTH (10),
        .RESET_BADV (RESET_BADV)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .lsu  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    logic [7:0]  mdl [4096];
    logic [31:0] e_wreg, e_m2reg, e_rn, e_alu, e_mdata;
    logic [31:0] e_adel, e_ades, e_badv;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mdl_load(input logic [31:0] alu,
                                             input bit uns, input bit half,
                                             input bit byt);
        int          n;
        int          base;
        logic [63:0] v;
        n    = byt ? 1 : (half ? 2 : 4);
        base = int'(alu[11:0]);
        base = base - (base % n);
        v    = 64'd0;
        for (int k = 0; k < n; k++) begin
            v = v | (64'(mdl[base+k]) << (8*k));
        end
        if (!uns && v[8*n-1]) begin
            v = v | ~((64'd1 << (8*n)) - 64'd1);
        end
        return v[31:0];
    endfunction

    task automatic cyc(input bit rst, input bit wreg, input bit m2reg,
                       input bit wmem, input logic [4:0] rn,
                       input logic [31:0] alu, input logic [31:0] b,
                       input bit uns, input bit half, input bit byt,
                       input bit ack);
        int n;
        int base;
        bit mis;
        bit adel;
        bit ades;
        clrn          = ~rst;
        bus.mem_wreg  = wreg;
        bus.mem_m2reg = m2reg;
        bus.mem_wmem  = wmem;
        bus.mem_rn    = rn;
        bus.mem_alu   = alu;
        bus.mem_b     = b;
        bus.mem_uns   = uns;
        bus.mem_half  = half;
        bus.mem_byte  = byt;
        bus.exc_ack   = ack;
        n    = byt ? 1 : (half ? 2 : 4);
        mis  = CHK && ((alu % n) != 0);
        adel = m2reg && mis;
        ades = wmem && mis;
        @(negedge clk);
        check("mem_adel", 32'(bus.mem_adel), 32'(adel));
        check("mem_ades", 32'(bus.mem_ades), 32'(ades));
        if (rst) begin
            e_wreg  = 0;
            e_m2reg = 0;
            e_rn    = 0;
            e_alu   = 0;
            e_mdata = 0;
            e_adel  = 0;
            e_ades  = 0;
            e_badv  = RESET_BADV;
        end else begin
            e_wreg  = 32'(wreg && !(adel || ades));
            e_m2reg = 32'(m2reg);
            e_rn    = 32'(rn);
            e_alu   = alu;
            e_mdata = mdl_load(alu, uns, half, byt);
            e_adel  = 32'(adel || (e_adel[0] && !ack));
            e_ades  = 32'(ades || (e_ades[0] && !ack));
            if (adel || ades) e_badv = alu;
            if (wmem && !ades) begin
                base = int'(alu[11:0]);
                base = base - (base % n);
                for (int k = 0; k < n; k++) begin
                    mdl[base+k] = b[8*k +: 8];
                end
            end
        end
        @(posedge clk);
        #1;
        check("wb_wreg", 32'(bus.wb_wreg), e_wreg);
        check("wb_m2reg", 32'(bus.wb_m2reg), e_m2reg);
        check("wb_rn", 32'(bus.wb_rn), e_rn);
        check("wb_alu", bus.wb_alu, e_alu);
        check("wb_mdata", bus.wb_mdata, e_mdata);
        check("exc_adel", 32'(bus.exc_adel), e_adel);
        check("exc_ades", 32'(bus.exc_ades), e_ades);
        check("badvaddr", bus.badvaddr, e_badv);
    endtask

    task automatic sw(input logic [31:0] addr, input logic [31:0] d);
        cyc(0, 0, 0, 1, 5'd0, addr, d, 0, 0, 0, 0);
    endtask

    task automatic ld(input logic [31:0] addr, input bit uns,
                      input bit half, input bit byt);
        cyc(0, 1, 1, 0, 5'd7, addr, 32'd0, uns, half, byt, 0);
    endtask

    initial begin
        bit wm;
        bit lm;
        logic [31:0] ad;
        n_chk         = 0;
        n_fail        = 0;
        e_adel        = 0;
        e_ades        = 0;
        e_badv        = RESET_BADV;
        clrn          = 1'b0;
        bus.mem_wreg  = 1'b0;
        bus.mem_m2reg = 1'b0;
        bus.mem_wmem  = 1'b0;
        bus.mem_rn    = 5'd0;
        bus.mem_alu   = 32'd0;
        bus.mem_b     = 32'd0;
        bus.mem_uns   = 1'b0;
        bus.mem_half  = 1'b0;
        bus.mem_byte  = 1'b0;
        bus.exc_ack   = 1'b0;
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 0, 0);

        for (int i = 0; i < 1024; i++) begin
            sw(32'(i) << 2, $urandom);
        end

        // reset with a store pending must not write
        sw(32'h40, 32'h5A5A_1234);
        cyc(0, 1, 1, 0, 5'd3, 32'h22, 32'd0, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 5'd9, 32'h40, 32'hDEAD_BEEF, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 5'd9, 32'h40, 32'hDEAD_BEEF, 0, 0, 0, 0);
        check("rst_wb_wreg", 32'(bus.wb_wreg), 32'd0);
        check("rst_exc_adel", 32'(bus.exc_adel), 32'd0);
        check("rst_badvaddr", bus.badvaddr, RESET_BADV);
        ld(32'h40, 0, 0, 0);
        check("rst_no_store", bus.wb_mdata, 32'h5A5A_1234);

        // byte lanes
        sw(32'h40, 32'h1122_3344);
        cyc(0, 0, 0, 1, 5'd0, 32'h42, 32'h0000_00AA, 0, 0, 1, 0);
        ld(32'h40, 0, 0, 0);
        check("byte_lane", bus.wb_mdata, 32'h11AA_3344);

        // extension
        sw(32'h10, 32'h80FF_7F01);
        ld(32'h13, 0, 0, 1);
        check("lb", bus.wb_mdata, 32'hFFFF_FF80);
        ld(32'h13, 1, 0, 1);
        check("lbu", bus.wb_mdata, 32'h0000_0080);
        ld(32'h12, 0, 1, 0);
        check("lh", bus.wb_mdata, 32'hFFFF_80FF);
        ld(32'h10, 1, 1, 0);
        check("lhu", bus.wb_mdata, 32'h0000_7F01);

        // misaligned load
        ld(32'h22, 0, 0, 0);
        check("adel_wreg", 32'(bus.wb_wreg), CHK ? 32'd0 : 32'd1);
        check("adel_flag", 32'(bus.exc_adel), 32'(CHK));
        check("adel_badv", bus.badvaddr, CHK ? 32'h22 : RESET_BADV);

        // misaligned store, then ack coinciding with a new load fault
        sw(32'h30, 32'h1234_5678);
        cyc(0, 0, 0, 1, 5'd0, 32'h31, 32'h0000_BEEF, 0, 1, 0, 1);
        check("ades_flag", 32'(bus.exc_ades), 32'(CHK));
        check("ades_badv", bus.badvaddr, CHK ? 32'h31 : RESET_BADV);
        ld(32'h30, 0, 0, 0);
        check("ades_nowrite", bus.wb_mdata,
              CHK ? 32'h1234_5678 : 32'h1234_BEEF);
        cyc(0, 1, 1, 0, 5'd4, 32'h5, 32'd0, 0, 0, 0, 1);
        check("ack_adel", 32'(bus.exc_adel), 32'(CHK));
        check("ack_ades", 32'(bus.exc_ades), 32'd0);
        check("ack_badv", bus.badvaddr, CHK ? 32'h5 : RESET_BADV);

        // wrap and back-to-back store then load
        sw(32'h1004, 32'hCAFE_F00D);
        ld(32'h0004, 0, 0, 0);
        check("wrap_b2b", bus.wb_mdata, 32'hCAFE_F00D);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            wm = ($urandom_range(0, 2) == 0);
            lm = ($urandom_range(0, 1) == 1);
            ad = $urandom;
            if ($urandom_range(0, 1) == 1) ad = ad & 32'h0000_003F;
            cyc(($urandom_range(0, 99) == 0), 1'($urandom), lm, wm,
                5'($urandom), ad, $urandom, 1'($urandom), 1'($urandom),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
